reg_arbiter: RTL
================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, register-port address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, register-port data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 m0_req  input  1  requester 0 transaction request; held with command stable until m0_ack.
REQ-006 m0_wr  input  1  requester 0 direction: 1 write, 0 read.
REQ-007 m0_addr  input  ADDR_W  requester 0 byte address.
REQ-008 m0_wdata  input  DATA_W  requester 0 write data.
REQ-009 m0_ack  output  1  one-cycle completion pulse to requester 0.
REQ-010 m0_err  output  1  valid with m0_ack; 1 = unaligned address, no access made.
REQ-011 m0_rdata  output  DATA_W  read data, valid with m0_ack on reads; 0 otherwise.
REQ-012 m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same directions, widths and meanings as m0_* for requester 1.
REQ-013 reg_wr_en  output  1  register-file write strobe.
REQ-014 reg_rd_en  output  1  register-file read strobe.
REQ-015 reg_addr  output  ADDR_W  register-file address.
REQ-016 reg_wdata  output  DATA_W  register-file write data.
REQ-017 reg_rdata  input  DATA_W  register-file read data, valid the cycle after a sampled reg_rd_en.
REQ-018 busy  output  1  1 whenever FSM is not IDLE.
REQ-019 gnt_id  output  1  index of requester owning the current transaction; 0 in IDLE.

Function
REQ-020 FSM SHALL have states IDLE, CMD, RESP only.
REQ-021 IDLE: if any req high, select winner, latch its wr/addr/wdata into internal command registers, set gnt_id, go CMD; else stay IDLE.
REQ-022 Arbitration SHALL be round-robin: single requester always wins; if both request, winner is the requester not served by the last completed transaction.
REQ-023 Last-served pointer SHALL update on entry to RESP.
REQ-024 CMD lasts exactly one cycle and always goes to RESP.
REQ-025 In CMD with aligned address (addr[1:0]==0): reg_wr_en = latched wr, reg_rd_en = !latched wr, reg_addr/reg_wdata = latched values.
REQ-026 In CMD with unaligned address: both strobes SHALL stay 0.
REQ-027 Outside CMD: reg_wr_en = reg_rd_en = 0; reg_addr and reg_wdata = 0.
REQ-028 RESP lasts exactly one cycle, asserts the granted requester's ack, then goes IDLE.
REQ-029 In RESP, granted mX_rdata = reg_rdata for an aligned read, else 0; mX_err = 1 only for an unaligned command.
REQ-030 Non-granted requester's ack/err/rdata SHALL be 0 in every cycle.
REQ-031 Latency: req sampled high in IDLE at edge N gives CMD in cycle N+1 and ack in cycle N+2; every transaction occupies 3 cycles including IDLE.
REQ-032 A req still high in the IDLE cycle after its ack SHALL be a new transaction.
REQ-033 Changes on a granted requester's inputs after latching SHALL NOT affect the current transaction.
REQ-034 At most one register strobe SHALL be high in any cycle.

Reset
REQ-035 rst high SHALL immediately, without waiting for clk, force IDLE, both strobes 0, all ack/err/rdata 0, busy 0, gnt_id 0, and last-served pointer 1 so requester 0 wins the first tie.
REQ-036 A transaction interrupted by reset SHALL be dropped without ack; requesters re-request after reset release.

Verification
REQ-037 Reset then m0 write addr 0x000 wdata 0xF0F0F0F0 -> reg_wr_en high exactly one cycle with addr 0x000/data 0xF0F0F0F0; m0_ack next cycle with m0_err=0.
REQ-038 m1 read addr 0x000 after REQ-037 -> reg_rd_en one cycle; m1_ack with m1_rdata 0xF0F0F0F0; m0 outputs stay 0.
REQ-039 m0 and m1 request together continuously just after reset -> grant order m0, m1, m0, m1; each ack 3 cycles apart; never two strobes at once.
REQ-040 m1 write addr 0x00F -> no strobe in CMD; m1_ack with m1_err=1, m1_rdata 0.
REQ-041 rst asserted mid-CMD of m0 write 0x008/0x15975312 -> strobes drop asynchronously, no m0_ack; a later read of 0x008 returns the value held before the aborted write.
REQ-042 m0 changes m0_addr from 0x004 to 0x00C during CMD -> register access still uses 0x004.

Source files
------------

// File: rtl/reg_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Each transaction is IDLE -> CMD (register strobe) -> RESP (ack to the winner).
module reg_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              gnt_id
);

   typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

   state_t            state, next_state;
   logic              gnt, last, cmd_wr, winner, aligned;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   // On a tie the requester not served last wins; otherwise the sole requester.
   assign winner  = (m0_req && m1_req) ? ~last : m1_req;
   assign aligned = (cmd_addr[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Command is captured once in IDLE so later requester changes cannot leak in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt       <= 1'b0;
         last      <= 1'b1;
         cmd_wr    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else begin
         if (state == IDLE && (m0_req || m1_req)) begin
            gnt       <= winner;
            cmd_wr    <= winner ? m1_wr    : m0_wr;
            cmd_addr  <= winner ? m1_addr  : m0_addr;
            cmd_wdata <= winner ? m1_wdata : m0_wdata;
         end
         if (state == CMD) last <= gnt;
      end
   end

   always_comb begin
      next_state = state;
      reg_wr_en  = 1'b0;
      reg_rd_en  = 1'b0;
      reg_addr   = '0;
      reg_wdata  = '0;
      m0_ack     = 1'b0;
      m0_err     = 1'b0;
      m0_rdata   = '0;
      m1_ack     = 1'b0;
      m1_err     = 1'b0;
      m1_rdata   = '0;
      busy       = (state != IDLE);
      gnt_id     = 1'b0;
      case (state)
         IDLE: if (m0_req || m1_req) next_state = CMD;
         CMD: begin
            next_state = RESP;
            gnt_id     = gnt;
            if (aligned) begin
               reg_wr_en = cmd_wr;
               reg_rd_en = ~cmd_wr;
               reg_addr  = cmd_addr;
               reg_wdata = cmd_wdata;
            end
         end
         RESP: begin
            next_state = IDLE;
            gnt_id     = gnt;
            if (gnt) begin
               m1_ack   = 1'b1;
               m1_err   = ~aligned;
               m1_rdata = (aligned && !cmd_wr) ? reg_rdata : '0;
            end else begin
               m0_ack   = 1'b1;
               m0_err   = ~aligned;
               m0_rdata = (aligned && !cmd_wr) ? reg_rdata : '0;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule
